// File: rtl/data_ram_wait.sv
// Wait-state data RAM: latches a request, stalls WAIT_CYCLES+1 cycles, and commits the write or presents the read word in one RESP cycle.
// While the core sees stallreq_o high it must hold. ce is ignored in RESP, and a new request is accepted on the following IDLE cycle.
module data_ram_wait #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                we_q, we_d;
   logic [3:0]          sel_q, sel_d;
   logic [31:0]         wdat_q, wdat_d;
   logic [31:0]         data_o_q, data_o_d;
   logic                last_wait;
   logic                unused_addr;

   // Only the word-index bits take part; the rest alias.
   assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

   assign last_wait  = (state_q == S_WAIT) && (cnt_q == 4'd0);
   assign stallreq_o = ((state_q == S_IDLE) && ce) || (state_q == S_WAIT);
   assign data_o     = data_o_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      we_d     = we_q;
      sel_d    = sel_q;
      wdat_d   = wdat_q;
      data_o_d = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (ce) begin
               idx_d   = addr[ADDR_W+1:2];
               we_d    = we;
               sel_d   = sel;
               wdat_d  = data_i;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_RESP;
               if (!we_q) data_o_d = mem[idx_q];
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         we_q     <= 1'b0;
         sel_q    <= 4'd0;
         wdat_q   <= 32'h0;
         data_o_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         wdat_q   <= wdat_d;
         data_o_q <= data_o_d;
      end
   end

   // Array contents survive reset; a reset mid-access drops state to IDLE so the write never fires.
   always_ff @(posedge clk) begin
      if (last_wait && we_q) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_ram_wait.sv
// Self-checking bench for data_ram_wait: directed scenarios plus randomized traffic against a word-array model.
module tb_data_ram_wait;
   localparam int WC = 2;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst, ce, we;
   logic [31:0] addr, data_i, data_o;
   logic [3:0]  sel;
   logic        stallreq_o;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ref_mem [int];

   data_ram_wait #(.WAIT_CYCLES(WC), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .data_o(data_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % (32'd1 << AW));
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] w;
      w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[widx(a)] = w;
   endfunction

   // Presents one request at T0, scrambles the other inputs while stalled, and returns the stall length and RESP-cycle data_o.
   task automatic run_access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                             input bit drop_ce, input bit hold_ce, output int nstall, output logic [31:0] resp);
      ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
      nstall = 0;
      #2;
      while (stallreq_o === 1'b1 && nstall < 40) begin
         nstall++;
         @(posedge clk); #1;
         if (drop_ce) ce = 1'b0;
         we = 1'($urandom); addr = $urandom; sel = 4'($urandom); data_i = $urandom;
         #2;
      end
      resp = data_o;
      ce = hold_ce;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (stallreq_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stallreq_o); end
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", data_o); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_word;
      int n; logic [31:0] r;
      run_access(1'b1, 32'h10, 4'hF, 32'h12345678, 1'b0, 1'b0, n, r);
      ref_write(32'h10, 4'hF, 32'h12345678);
      checks++;
      if (n !== WC + 1) begin failures++; $display("FAIL fw_write_stall: got %0d cycles expected %0d", n, WC + 1); end
      checks++;
      if (r !== 32'h0) begin failures++; $display("FAIL fw_write_resp: got %h expected 00000000", r); end
      run_access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, n, r);
      checks++;
      if (n !== WC + 1) begin failures++; $display("FAIL fw_read_stall: got %0d cycles expected %0d", n, WC + 1); end
      checks++;
      if (r !== ref_mem[widx(32'h10)]) begin failures++; $display("FAIL fw_read_data: got %h expected %h", r, ref_mem[widx(32'h10)]); end
      #1;
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL fw_idle_data: got %h expected 00000000", data_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_byte_write;
      int n; logic [31:0] r;
      run_access(1'b1, 32'h10, 4'b0010, 32'h0000AB00, 1'b0, 1'b0, n, r);
      ref_write(32'h10, 4'b0010, 32'h0000AB00);
      run_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, n, r);
      checks++;
      if (r !== ref_mem[widx(32'h10)]) begin failures++; $display("FAIL byte_write: got %h expected %h", r, ref_mem[widx(32'h10)]); end
      run_access(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b0, n, r);
      checks++;
      if (n !== WC + 1) begin failures++; $display("FAIL sel0_stall: got %0d cycles expected %0d", n, WC + 1); end
      run_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, n, r);
      checks++;
      if (r !== ref_mem[widx(32'h10)]) begin failures++; $display("FAIL sel0_write: got %h expected %h", r, ref_mem[widx(32'h10)]); end
   endtask

   task automatic test_back_to_back;
      int n1, n2; logic [31:0] r1, r2;
      run_access(1'b1, 32'h14, 4'hF, 32'h11111111, 1'b0, 1'b0, n1, r1);
      ref_write(32'h14, 4'hF, 32'h11111111);
      run_access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b1, n1, r1);
      run_access(1'b0, 32'h14, 4'hF, 32'h0, 1'b0, 1'b0, n2, r2);
      checks++;
      if (n1 !== WC + 1 || n2 !== WC + 1) begin
         failures++; $display("FAIL b2b_stall: got %0d,%0d cycles expected %0d each", n1, n2, WC + 1);
      end
      checks++;
      if (r1 !== ref_mem[widx(32'h10)]) begin failures++; $display("FAIL b2b_first: got %h expected %h", r1, ref_mem[widx(32'h10)]); end
      checks++;
      if (r2 !== ref_mem[widx(32'h14)]) begin failures++; $display("FAIL b2b_second: got %h expected %h", r2, ref_mem[widx(32'h14)]); end
   endtask

   task automatic test_ce_drop;
      int n; logic [31:0] r;
      run_access(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, n, r);
      ref_write(32'h20, 4'hF, 32'hCAFEF00D);
      checks++;
      if (n !== WC + 1) begin failures++; $display("FAIL ce_drop_stall: got %0d cycles expected %0d", n, WC + 1); end
      run_access(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0, n, r);
      checks++;
      if (r !== ref_mem[widx(32'h20)]) begin failures++; $display("FAIL ce_drop_data: got %h expected %h", r, ref_mem[widx(32'h20)]); end
   endtask

   task automatic test_reset_mid;
      int n; logic [31:0] r;
      run_access(1'b1, 32'h24, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, n, r);
      ref_write(32'h24, 4'hF, 32'hDEADBEEF);
      ce = 1'b1; we = 1'b1; addr = 32'h24; sel = 4'hF; data_i = 32'h0;
      @(posedge clk); #1;
      ce = 1'b0;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (stallreq_o !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got %b expected 0", stallreq_o); end
      checks++;
      if (data_o !== 32'h0) begin failures++; $display("FAIL rst_mid_data: got %h expected 00000000", data_o); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      run_access(1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 1'b0, n, r);
      checks++;
      if (r !== ref_mem[widx(32'h24)]) begin failures++; $display("FAIL rst_mid_mem: got %h expected %h", r, ref_mem[widx(32'h24)]); end
   endtask

   task automatic test_alias;
      int n; logic [31:0] r;
      run_access(1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, n, r);
      ref_write(32'h1000, 4'hF, 32'hA5A5A5A5);
      run_access(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, n, r);
      checks++;
      if (r !== ref_mem[widx(32'h0)]) begin failures++; $display("FAIL alias: got %h expected %h", r, ref_mem[widx(32'h0)]); end
   endtask

   task automatic test_random;
      int n; logic [31:0] r, a, d, exp_r;
      int idxs [8];
      logic w; logic [3:0] s; bit drop, hold;
      for (int i = 0; i < 8; i++) begin
         idxs[i] = 64 + int'($urandom_range(0, 900));
         d = $urandom;
         run_access(1'b1, 32'(idxs[i]) << 2, 4'hF, d, 1'b0, 1'b0, n, r);
         ref_write(32'(idxs[i]) << 2, 4'hF, d);
      end
      for (int k = 0; k < 40; k++) begin
         a = ($urandom & ~32'h00000FFC) | (32'(idxs[$urandom_range(0, 7)]) << 2);
         w = 1'($urandom); s = 4'($urandom); d = $urandom;
         drop = 1'($urandom); hold = 1'($urandom);
         exp_r = w ? 32'h0 : ref_mem[widx(a)];
         run_access(w, a, s, d, drop, hold, n, r);
         if (w) ref_write(a, s, d);
         checks++;
         if (n !== WC + 1 || r !== exp_r) begin
            failures++;
            $display("FAIL random_%0d: we=%b addr=%h got stall=%0d data=%h expected stall=%0d data=%h", k, w, a, n, r, WC + 1, exp_r);
         end
      end
      ce = 1'b0;
   endtask

   initial begin
      test_reset;
      test_full_word;
      test_byte_write;
      test_back_to_back;
      test_ce_drop;
      test_reset_mid;
      test_alias;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
